sram_port_arbiter: RTL and testbench
====================================

// Module: sram_port_arbiter
// PURPOSE
//  Two-requester synchronous front end for the 1024x8 asynchronous SRAM (bidirectional data_io,
//  read_write_select 1=write/0=read, chip_select active-high). Accepts read/write commands on two
//  valid/ready ports, arbitrates round-robin and sequences the SRAM pins with fixed setup/strobe/hold
//  phases. Returns read data on a per-port response strobe. Sits between core logic and the SRAM instance.
// PARAMETERS
//  ADDR_W     10  SRAM address width (1024 words)
//  DATA_W      8  SRAM data width
//  WR_CYCLES   2  clocks read_write_select is held 1 (write strobe), >=1
//  RD_CYCLES   2  clocks from read address valid to data capture, >=1
// PORTS
//  clk                    in     1       system clock, rising edge
//  rst                    in     1       asynchronous reset, active-high
//  req0_valid / req1_valid  in   1       command valid, port 0 / port 1
//  req0_ready / req1_ready  out  1       command accepted this cycle when valid&ready
//  req0_we / req1_we      in     1       1=write, 0=read
//  req0_addr / req1_addr  in     ADDR_W  word address
//  req0_wdata / req1_wdata in    DATA_W  write data
//  rsp0_valid / rsp1_valid out   1       one-cycle pulse: read data valid for that port
//  rsp_rdata              out    DATA_W  captured read data (shared, qualified by rspN_valid)
//  sram_address           out    ADDR_W  to SRAM address
//  sram_data_io           inout  DATA_W  to SRAM data_io; driven only in write strobe, else Z
//  sram_rws               out    1       to SRAM read_write_select
//  sram_cs                out    1       to SRAM chip_select
//  busy                   out    1       1 whenever state != IDLE
// BEHAVIOUR
//  Reset (async, immediate): state=IDLE, sram_cs=0, sram_rws=0, sram_data_io=Z, sram_address=0,
//   reqN_ready=0, rspN_valid=0, rsp_rdata=0, busy=0, round-robin pointer=port0 (last_grant=1).
//  Reset asserted mid-access aborts it at once: rws drops to 0 and bus releases same instant; no response.
//  All SRAM-side outputs are registered; no combinational path from req inputs to SRAM pins.
//  States: IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_WAIT, R_CAPTURE.
//  IDLE: if any reqN_valid, grant: only one valid -> it; both -> port != last_grant. Assert
//   reqN_ready for that port this cycle (combinational from state+valid), latch addr/we/wdata,
//   update last_grant, go W_SETUP (we=1) or R_SETUP (we=0). ready is 0 in every other state.
//  W_SETUP (1 clk): sram_cs=1, sram_address=addr, sram_rws=0, bus Z.
//  W_STROBE (WR_CYCLES clks): sram_rws=1, sram_data_io=wdata; address/data stable throughout.
//  W_HOLD (1 clk): sram_rws=0, bus Z, address still held; then IDLE, cs=0.
//  R_SETUP (1 clk): cs=1, rws=0, address=addr, bus Z.
//  R_WAIT (RD_CYCLES clks): address held. R_CAPTURE (1 clk): rsp_rdata<=sram_data_io,
//   rspN_valid=1 for the granted port on the next cycle (in IDLE), then IDLE.
//  Latency: write = 2+WR_CYCLES clks accept-to-IDLE; read = 2+RD_CYCLES clks accept-to-rsp_valid.
//  Back-to-back: a new grant may occur in the IDLE cycle right after a hold/capture; cs goes 0 for
//   that one cycle. rsp pulse for a read may coincide with the next grant.
//  Strobe-phase counter is ceil(log2(max(WR_CYCLES,RD_CYCLES)+1)) bits, cleared on every state entry.
//  Address outside 0..2^ADDR_W-1 impossible by width; no wrap logic needed.
//  Requester must hold valid and payload stable until ready; dropping valid before ready is allowed.
//  Bus never driven by this block while sram_rws=0 (no contention with SRAM read drive).
// TESTING
//  1 Reset: assert rst mid W_STROBE -> rws=0, data_io=Z, cs=0 immediately; no rsp, busy=0.
//  2 Port0 write addr=0x005 data=0xA5, then port0 read 0x005 -> rsp0_valid pulse, rsp_rdata=0xA5,
//    write occupies 4 clks, read rsp 4 clks after accept (defaults).
//  3 Both valid every cycle, writes of addr=i/data=2i alternating ports -> grants strictly
//    0,1,0,1; readback of 0..1023 returns 2i mod 256 on correct rsp port.
//  4 Only port1 valid continuously -> granted every access, no bubbles beyond the 1-clk IDLE.
//  5 Check bus: data_io==Z whenever sram_rws==0 across all of test 3; address stable during strobe.
//  6 Port1 drops valid before ready while port0 busy -> no access issued for port1.

Source files
------------

// File: rtl/sram_port_arbiter.sv
// rtl/sram_port_arbiter.sv - two-port round-robin front end sequencing an asynchronous 1024x8 SRAM
module sram_port_arbiter #(
    parameter int ADDR_W    = 10,
    parameter int DATA_W    = 8,
    parameter int WR_CYCLES = 2,
    parameter int RD_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              req0_valid,
    output logic              req0_ready,
    input  logic              req0_we,
    input  logic [ADDR_W-1:0] req0_addr,
    input  logic [DATA_W-1:0] req0_wdata,
    input  logic              req1_valid,
    output logic              req1_ready,
    input  logic              req1_we,
    input  logic [ADDR_W-1:0] req1_addr,
    input  logic [DATA_W-1:0] req1_wdata,
    output logic              rsp0_valid,
    output logic              rsp1_valid,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic [ADDR_W-1:0] sram_address,
    inout  wire  [DATA_W-1:0] sram_data_io,
    output logic              sram_rws,
    output logic              sram_cs,
    output logic              busy
);
    localparam int MAX_CYC = (WR_CYCLES > RD_CYCLES) ? WR_CYCLES : RD_CYCLES;
    localparam int CNT_W   = $clog2(MAX_CYC + 1);

    typedef enum logic [2:0] {
        IDLE, W_SETUP, W_STROBE, W_HOLD, R_SETUP, R_WAIT, R_CAPTURE
    } state_t;

    state_t            state, next_state;
    logic [CNT_W-1:0]  cnt;
    logic              last_grant;
    logic              port_q;
    logic [DATA_W-1:0] wdata_q;
    logic              grant;
    logic              grant_port;
    logic              we_sel;
    logic [ADDR_W-1:0] addr_sel;
    logic [DATA_W-1:0] wdata_sel;

    // With both ports valid the port that did not win last time goes next.
    always_comb begin
        grant      = (state == IDLE) && (req0_valid || req1_valid);
        grant_port = (req0_valid && req1_valid) ? ~last_grant : req1_valid;
        we_sel     = grant_port ? req1_we    : req0_we;
        addr_sel   = grant_port ? req1_addr  : req0_addr;
        wdata_sel  = grant_port ? req1_wdata : req0_wdata;
    end

    assign req0_ready = grant && !grant_port;
    assign req1_ready = grant && grant_port;
    assign busy       = (state != IDLE);

    always_comb begin
        next_state = state;
        unique case (state)
            IDLE:      if (grant) next_state = we_sel ? W_SETUP : R_SETUP;
            W_SETUP:   next_state = W_STROBE;
            W_STROBE:  if (cnt == CNT_W'(WR_CYCLES - 1)) next_state = W_HOLD;
            W_HOLD:    next_state = IDLE;
            R_SETUP:   next_state = R_WAIT;
            R_WAIT:    if (cnt == CNT_W'(RD_CYCLES - 1)) next_state = R_CAPTURE;
            R_CAPTURE: next_state = IDLE;
            default:   next_state = IDLE;
        endcase
    end

    // Pin registers are loaded from next_state so they change together with the state.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state        <= IDLE;
            cnt          <= '0;
            last_grant   <= 1'b1;
            port_q       <= 1'b0;
            wdata_q      <= '0;
            sram_address <= '0;
            sram_rws     <= 1'b0;
            sram_cs      <= 1'b0;
            rsp0_valid   <= 1'b0;
            rsp1_valid   <= 1'b0;
            rsp_rdata    <= '0;
        end else begin
            state    <= next_state;
            cnt      <= (next_state != state) ? '0 : cnt + 1'b1;
            sram_cs  <= (next_state != IDLE);
            sram_rws <= (next_state == W_STROBE);
            if (grant) begin
                last_grant   <= grant_port;
                port_q       <= grant_port;
                sram_address <= addr_sel;
                wdata_q      <= wdata_sel;
            end
            rsp0_valid <= (state == R_CAPTURE) && !port_q;
            rsp1_valid <= (state == R_CAPTURE) && port_q;
            if (state == R_CAPTURE) rsp_rdata <= sram_data_io;
        end
    end

    // The bus is driven only while the write strobe is asserted.
    assign sram_data_io = sram_rws ? wdata_q : {DATA_W{1'bz}};

endmodule

// File: tb/tb_sram_port_arbiter.sv
// tb/tb_sram_port_arbiter.sv - randomized self-checking bench for sram_port_arbiter with SRAM and reference model
module tb_sram_port_arbiter;
    localparam int AW  = 10;
    localparam int DW  = 8;
    localparam int WRC = 2;
    localparam int RDC = 2;

    logic          clk = 1'b0;
    logic          rst;
    logic          req0_valid, req0_ready, req0_we;
    logic [AW-1:0] req0_addr;
    logic [DW-1:0] req0_wdata;
    logic          req1_valid, req1_ready, req1_we;
    logic [AW-1:0] req1_addr;
    logic [DW-1:0] req1_wdata;
    logic          rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp_rdata;
    logic [AW-1:0] sram_address;
    wire  [DW-1:0] sram_data_io;
    logic          sram_rws, sram_cs, busy;

    sram_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_CYCLES(WRC), .RD_CYCLES(RDC)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_we(req0_we),
        .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_we(req1_we),
        .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .rsp0_valid(rsp0_valid), .rsp1_valid(rsp1_valid), .rsp_rdata(rsp_rdata),
        .sram_address(sram_address), .sram_data_io(sram_data_io),
        .sram_rws(sram_rws), .sram_cs(sram_cs), .busy(busy)
    );

    always #5 clk = ~clk;

    // Asynchronous SRAM: drives the bus on a read, stores while the write strobe is high.
    logic [DW-1:0] sram_mem [0:(1<<AW)-1];
    assign sram_data_io = (sram_cs && !sram_rws) ? sram_mem[sram_address] : {DW{1'bz}};
    always @(posedge clk) if (sram_cs && sram_rws) sram_mem[sram_address] <= sram_data_io;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end
    endtask

    // Reference model: an access occupies the SRAM for a fixed number of cycles after acceptance.
    logic [DW-1:0] ref_mem [0:(1<<AW)-1];
    logic          mon_en = 1'b0;
    int            m_rem, m_total, m_last, m_rsp_cd, m_rsp_port;
    logic [DW-1:0] m_rsp_data, m_wdata;
    logic [AW-1:0] m_addr;
    logic          m_we;
    logic          acc0, acc1;

    always @(negedge clk) begin : monitor
        int exp_g;
        int ph;
        acc0 = req0_valid && req0_ready;
        acc1 = req1_valid && req1_ready;
        if (mon_en) begin
            check("rsp0_valid", rsp0_valid, (m_rsp_cd == 1) && (m_rsp_port == 0));
            check("rsp1_valid", rsp1_valid, (m_rsp_cd == 1) && (m_rsp_port == 1));
            if (m_rsp_cd == 1) check("rsp_rdata", rsp_rdata, m_rsp_data);
            if (m_rsp_cd > 0) m_rsp_cd--;
            check("busy", busy, m_rem > 0);
            check("sram_cs", sram_cs, m_rem > 0);
            if (m_rem > 0) begin
                ph = m_total - m_rem;
                check("sram_address", sram_address, m_addr);
                check("sram_rws", sram_rws, m_we && ph >= 1 && ph <= WRC);
            end else begin
                check("sram_rws_idle", sram_rws, 0);
            end
            if (sram_rws) check("bus_wdata", sram_data_io, m_wdata);
            else if (sram_cs) check("bus_sram_drive", sram_data_io, sram_mem[sram_address]);
            exp_g = -1;
            if (m_rem == 0 && (req0_valid || req1_valid))
                exp_g = (req0_valid && req1_valid) ? 1 - m_last : (req1_valid ? 1 : 0);
            check("req0_ready", req0_ready, exp_g == 0);
            check("req1_ready", req1_ready, exp_g == 1);
            if (m_rem > 0) begin
                m_rem--;
            end else if (exp_g >= 0) begin
                m_last  = exp_g;
                m_we    = (exp_g == 0) ? req0_we    : req1_we;
                m_addr  = (exp_g == 0) ? req0_addr  : req1_addr;
                m_wdata = (exp_g == 0) ? req0_wdata : req1_wdata;
                m_total = m_we ? 2 + WRC : 2 + RDC;
                m_rem   = m_total;
                if (m_we) begin
                    ref_mem[m_addr] = m_wdata;
                end else begin
                    m_rsp_cd   = 2 + RDC + 1;
                    m_rsp_port = exp_g;
                    m_rsp_data = ref_mem[m_addr];
                end
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set0(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic set1(input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    task automatic drain();
        int k = 0;
        req0_valid = 1'b0;
        req1_valid = 1'b0;
        while ((busy || rsp0_valid || rsp1_valid) && k < 50) begin tick(); k++; end
        tick();
        check("drain_timeout", busy, 0);
    endtask

    initial begin
        int k, i0, i1, cyc, last_cyc, prev_lat, n1;
        logic [DW-1:0] v;
        int gq[$];

        rst = 1'b1;
        req0_valid = 1'b0; req1_valid = 1'b0;
        set0(1'b0, '0, '0); set1(1'b0, '0, '0);
        for (int i = 0; i < (1 << AW); i++) begin
            v = 8'($urandom);
            ref_mem[i] = v;
            sram_mem[i] <= v;
        end
        repeat (3) tick();
        check("rst_busy", busy, 0);
        check("rst_cs", sram_cs, 0);
        check("rst_rws", sram_rws, 0);
        check("rst_address", sram_address, 0);
        check("rst_rsp", {rsp0_valid, rsp1_valid}, 0);
        check("rst_rdata", rsp_rdata, 0);

        // Reset mid write strobe aborts the access immediately
        rst = 1'b0;
        tick();
        set0(1'b1, 10'h055, 8'h3C);
        req0_valid = 1'b1;
        k = 0;
        @(negedge clk);
        while (!sram_rws && k < 20) begin @(negedge clk); k++; end
        check("t1_reached_strobe", sram_rws, 1);
        #1 rst = 1'b1;
        #1;
        check("t1_rws_abort", sram_rws, 0);
        check("t1_cs_abort", sram_cs, 0);
        check("t1_busy_abort", busy, 0);
        check("t1_rsp_abort", {rsp0_valid, rsp1_valid}, 0);
        req0_valid = 1'b0;
        repeat (2) tick();
        rst = 1'b0;
        m_rem = 0; m_total = 0; m_last = 1; m_rsp_cd = 0; m_rsp_port = 0; m_we = 1'b0;
        mon_en = 1'b1;
        repeat (6) begin tick(); check("t1_no_rsp", {rsp0_valid, rsp1_valid}, 0); end

        // Port 0 write then read back, with latencies
        set0(1'b1, 10'h005, 8'hA5);
        req0_valid = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!acc0 && k < 20);
        req0_valid = 1'b0;
        k = 0;
        while (busy && k < 20) begin tick(); k++; end
        check("t2_wr_latency", k, 2 + WRC);
        set0(1'b0, 10'h005, 8'h00);
        req0_valid = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!acc0 && k < 20);
        req0_valid = 1'b0;
        k = 0;
        while (!rsp0_valid && k < 20) begin tick(); k++; end
        check("t2_rd_latency", k, 2 + RDC);
        check("t2_rdata", rsp_rdata, 8'hA5);
        drain();

        // Both ports contending: writes of 2i to every address, then full readback
        for (int ph = 0; ph < 2; ph++) begin
            i0 = 0; i1 = 1; cyc = 0;
            set0(ph == 0, AW'(i0), 8'(2 * i0));
            set1(ph == 0, AW'(i1), 8'(2 * i1));
            req0_valid = 1'b1; req1_valid = 1'b1;
            while ((req0_valid || req1_valid) && cyc < 20000) begin
                tick(); cyc++;
                if (acc0) begin
                    gq.push_back(0); i0 += 2;
                    if (i0 < (1 << AW)) set0(ph == 0, AW'(i0), 8'(2 * i0)); else req0_valid = 1'b0;
                end
                if (acc1) begin
                    gq.push_back(1); i1 += 2;
                    if (i1 < (1 << AW)) set1(ph == 0, AW'(i1), 8'(2 * i1)); else req1_valid = 1'b0;
                end
            end
            check("t3_phase_timeout", cyc < 20000, 1);
        end
        drain();
        check("t3_grant_count", gq.size(), 2 * (1 << AW));
        for (int g = 1; g < gq.size(); g++) check("t3_alternate", gq[g], 1 - gq[g-1]);

        // Port 1 alone, continuously valid: an access every op latency plus one IDLE cycle
        n1 = 0; cyc = 0; last_cyc = -1; prev_lat = 0;
        set1(1'($urandom), AW'($urandom), 8'($urandom));
        req1_valid = 1'b1;
        while (n1 < 40 && cyc < 1000) begin
            tick(); cyc++;
            if (acc1) begin
                if (last_cyc >= 0) check("t4_spacing", cyc - last_cyc, prev_lat + 1);
                last_cyc = cyc;
                prev_lat = req1_we ? 2 + WRC : 2 + RDC;
                n1++;
                set1(1'($urandom), AW'($urandom), 8'($urandom));
            end
        end
        check("t4_count", n1, 40);
        drain();

        // Port 1 withdraws its request while port 0 is being served
        n1 = 0;
        set0(1'b1, 10'h200, 8'h5A);
        req0_valid = 1'b1;
        tick();
        req0_valid = 1'b0;
        set1(1'b1, 10'h3FF, 8'hC3);
        req1_valid = 1'b1;
        tick(); if (acc1) n1++;
        tick(); if (acc1) n1++;
        req1_valid = 1'b0;
        repeat (10) begin tick(); if (acc1) n1++; end
        check("t6_no_port1_access", n1, 0);
        set1(1'b0, 10'h3FF, 8'h00);
        req1_valid = 1'b1;
        k = 0;
        do begin tick(); k++; end while (!acc1 && k < 20);
        req1_valid = 1'b0;
        drain();

        // Random traffic on both ports over a small address window
        for (int c = 0; c < 3000; c++) begin
            if (req0_valid && acc0) req0_valid = ($urandom_range(0, 9) < 7);
            else if (req0_valid) req0_valid = ($urandom_range(0, 7) != 0);
            else req0_valid = $urandom_range(0, 1);
            if (req0_valid && (acc0 || !req0_ready))
                if (acc0 || $urandom_range(0, 1)) set0(1'($urandom), AW'($urandom_range(0, 15)), 8'($urandom));
            if (req1_valid && acc1) req1_valid = ($urandom_range(0, 9) < 7);
            else if (req1_valid) req1_valid = ($urandom_range(0, 7) != 0);
            else req1_valid = $urandom_range(0, 1);
            if (req1_valid && acc1) set1(1'($urandom), AW'($urandom_range(0, 15)), 8'($urandom));
            tick();
        end
        drain();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
